hazard_scoreboard_unit: RTL

HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

---
 rtl/hazard_scoreboard_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose:
//   Load-use hazard detection for a classic 5-stage in-order pipeline, built
//   around a small scoreboard. Three shadow slots (EX, MEM, WB) mirror the
//   producer side of the ID/EX, EX/MEM and MEM/WB pipeline registers. From
//   them the block derives:
//     * a one-cycle load-use stall when the instruction in ID reads the
//       destination of a load currently in EX
//     * a per-register "write in flight" vector (Pending)
//     * a saturating count of stall cycles since reset
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous, active-high
//   IF_ID_RS      in   [4:0] rs of the ID instruction
//   IF_ID_RT      in   [4:0] rt of the ID instruction
//   ID_Uses_RT    in   ID instruction reads rt as a source
//   ID_Valid      in   ID holds a real (non-bubble) instruction
//   ID_Reg_Write  in   ID instruction writes a register
//   ID_Mem_Read   in   ID instruction is a load
//   ID_RD         in   [4:0] destination register of the ID instruction
//   Flush         in   squash the ID instruction this cycle
//   Stall         out  load-use hazard this cycle (combinational)
//   PC_Write      out  PC update enable (~Stall)
//   IF_ID_Write   out  IF/ID update enable (~Stall)
//   ID_EX_Bubble  out  zero the control fields entering ID/EX (Stall|Flush)
//   Pending       out  [31:0] bit n set while register n has a write in flight
//   Stall_Count   out  [STALL_CNT_W-1:0] saturating stall-cycle counter
//
// Handshake: there is no valid/ready pair. ID_Valid qualifies the ID-stage
// inputs every cycle; Stall is the back-pressure, and while it is high the
// upstream stages must hold IF/ID and the PC so the same consumer is
// presented again on the following cycle.
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             IF_ID_RS,
  input  logic [4:0]             IF_ID_RT,
  input  logic                   ID_Uses_RT,
  input  logic                   ID_Valid,
  input  logic                   ID_Reg_Write,
  input  logic                   ID_Mem_Read,
  input  logic [4:0]             ID_RD,
  input  logic                   Flush,
  output logic                   Stall,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   ID_EX_Bubble,
  output logic [31:0]            Pending,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  // ---------------------------------------------------------------------------
  // Shadow slots. Only the EX slot's load flag can ever cause a stall (older
  // loads are covered by forwarding), so the MEM and WB slots carry just
  // valid and rd; the load flag is dropped as the entry leaves EX.
  // ---------------------------------------------------------------------------
  logic             ex_vld_q,  ex_vld_d;
  logic [4:0]       ex_rd_q,   ex_rd_d;
  logic             ex_ld_q,   ex_ld_d;
  logic             mem_vld_q;
  logic [4:0]       mem_rd_q;
  logic             wb_vld_q;
  logic [4:0]       wb_rd_q;

  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic             rs_match;
  logic             rt_match;
  logic             hazard;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign rs_match = (ex_rd_q == IF_ID_RS);
  assign rt_match = ID_Uses_RT & (ex_rd_q == IF_ID_RT);

  // Flush dominates: a squashed consumer never stalls. A valid EX entry never
  // has rd=0, so matches on register 0 fall out naturally.
  assign hazard = ID_Valid & ~Flush & ex_vld_q & ex_ld_q & (rs_match | rt_match);

  // Slots are already cleared asynchronously during reset; the extra gate
  // keeps Stall low for the whole reset window independent of slot timing.
  assign Stall        = hazard & ~reset;
  assign PC_Write     = ~Stall;
  assign IF_ID_Write  = ~Stall;
  assign ID_EX_Bubble = Stall | Flush;

  // ---------------------------------------------------------------------------
  // EX slot next state: a stalled or flushed ID instruction enters ID/EX as a
  // bubble, so its shadow entry is invalid.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_vld_d = 1'b0;
    ex_rd_d  = 5'd0;
    ex_ld_d  = 1'b0;
    if (!(Stall || Flush)) begin
      ex_vld_d = ID_Valid & ID_Reg_Write & (ID_RD != 5'd0);
      ex_rd_d  = ID_RD;
      ex_ld_d  = ID_Mem_Read;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (Stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  assign Stall_Count = cnt_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_vld_q  <= 1'b0;
      ex_rd_q   <= 5'd0;
      ex_ld_q   <= 1'b0;
      mem_vld_q <= 1'b0;
      mem_rd_q  <= 5'd0;
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= 5'd0;
      cnt_q     <= '0;
    end else begin
      wb_vld_q  <= mem_vld_q;
      wb_rd_q   <= mem_rd_q;
      mem_vld_q <= ex_vld_q;
      mem_rd_q  <= ex_rd_q;
      ex_vld_q  <= ex_vld_d;
      ex_rd_q   <= ex_rd_d;
      ex_ld_q   <= ex_ld_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending: OR of one-hot decodes of every valid slot. Back-to-back writers
  // of the same rd sit in different slots, so the bit stays up until the last
  // of them retires. Bit 0 is masked for safety even though rd=0 is never
  // marked valid.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] slot_onehot(input logic vld, input logic [4:0] rd);
    logic [31:0] r;
    r = 32'd0;
    if (vld) r[rd] = 1'b1;
    return r;
  endfunction

  assign Pending = (slot_onehot(ex_vld_q,  ex_rd_q)  |
                    slot_onehot(mem_vld_q, mem_rd_q) |
                    slot_onehot(wb_vld_q,  wb_rd_q)) & ~32'h1;

endmodule
